dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 2K×32 data memory macro between two requesters: port 0, the execute stage's load/store path, and port 1, the data loader/debug DMA. Port 0 has fixed priority, and a starvation counter forces a grant to port 1 after a bounded wait. The block drives the RAM's active-low CEN/WEN/OEN pins and steers the one-cycle-latency read data back to whichever port issued the read.

## Interface
- ADDR_W, 11, memory word-address width (2K words)
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied while waiting before it is forced through; legal range 1..15
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_valid / p1_valid  in  1  request valid
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_ready / p1_ready  out  1  request accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  read data valid (registered pulse)
- p0_rdata / p1_rdata  out  DATA_W  read data; mem_q when the matching rvalid is 1, else 0
- mem_cen  out  1  RAM chip enable, active low
- mem_wen  out  1  RAM write enable, active low
- mem_oen  out  1  RAM output enable, active low; tied 0
- mem_addr  out  ADDR_W  RAM address
- mem_d  out  DATA_W  RAM write data
- mem_q  in  DATA_W  RAM read data, valid the cycle after the access edge

## Operation
- Grant decision is combinational each cycle:
  - Only one port valid: that port is granted.
  - Both valid and starve_cnt == STARVE_LIMIT: port 1 is granted.
  - Both valid otherwise: port 0 is granted.
  - No port valid: no grant.
- pX_ready = grant to X. At most one ready is high per cycle. Both readies are 0 while rst_n is low.
- RAM drive when granted: mem_cen=0, mem_wen=~pX_we, mem_addr=pX_addr, mem_d=pX_wdata.
- RAM drive when not granted: mem_cen=1, mem_wen=1, mem_addr=0, mem_d=0.
- starve_cnt (4-bit register) updates as follows:
  - Cleared when port 1 is granted or p1_valid=0.
  - Incremented when p1_valid=1 and port 0 is granted.
  - Never exceeds STARVE_LIMIT.
- rd_owner register (2 bits: valid and port id) is loaded at each edge where a read is granted. It is cleared at an edge with no read grant.
- pX_rvalid = rd_owner.valid && rd_owner.id==X. pX_rdata = mem_q gated by pX_rvalid.
- Writes produce no rvalid. The write completes at the grant edge.
- Requesters hold valid, we, addr and wdata stable until ready. Changing a request before ready is legal; the arbiter simply evaluates the new value.

## Timing
- Grant in cycle N; the RAM samples at the rising edge ending cycle N. Read data and rvalid appear in cycle N+1. Read latency is 1 cycle.
- Throughput is one access per cycle, with back-to-back grants to the same or alternating ports.
- Read-after-write at the same address: a write granted in N followed by a read granted in N+1 returns the new data in N+2. No forwarding is needed; the RAM is write-first per edge ordering.
- Simultaneous read and write requests to the same address from both ports: only one is granted. The loser waits, and its result reflects the winner's effect.
- Reset values, asserted immediately on rst_n falling:
  - p0_ready=0, p1_ready=0, p0_rvalid=0, p1_rvalid=0, p0_rdata=0, p1_rdata=0
  - mem_cen=1, mem_wen=1, mem_oen=0, mem_addr=0, mem_d=0
  - starve_cnt=0, rd_owner invalid
- Reset mid-read: a read granted in the cycle before reset asserts produces no rvalid after reset releases.
- First grant is possible in the first cycle with rst_n high.

## Test plan
- Reset: hold rst_n=0 with both ports valid. Required: all outputs at reset values and mem_cen=1. Release rst_n; port 0 is granted in that same cycle.
- Single read: preload word 0x005 = 0x1234_5678; p0 reads 0x005 alone. Required: p0_ready=1 in cycle N; p0_rvalid=1 and p0_rdata=0x1234_5678 in N+1; p1_rvalid stays 0.
- Contention with STARVE_LIMIT=4: both ports continuously valid with reads. Required: grant sequence p0,p0,p0,p0,p1 repeating, and each rvalid pulse lands only on the owning port.
- Counter clear: p1 waits 3 cycles, drops valid for 1 cycle, then re-requests. Required: the count restarts, so port 1 is next forced through only after 4 further denials.
- Write then read: p1 writes 0xDEAD_BEEF to 0x7FF in N; p0 reads 0x7FF in N+1. Required: p0_rdata=0xDEAD_BEEF in N+2 and mem_wen=0 only in N.
- Reset mid-read: p0 read granted in N and rst_n falls during N+1 before the edge. Required: p0_rvalid=0 after release, and no stale data appears on either port.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port 2Kx32 data RAM: port 0 wins by default,
// and a starvation counter forces port 1 through after STARVE_LIMIT consecutive denials.
module dmem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic              mem_oen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic valid;
    logic id;
  } rd_owner_t;

  logic      grant0;
  logic      grant1;
  logic      read_grant;
  logic [3:0] starve_cnt;
  rd_owner_t rd_owner;

  // Grants are forced low during reset so nothing reaches the RAM while rst_n is low.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (p1_valid && (!p0_valid || starve_cnt == LIMIT)) grant1 = 1'b1;
      else if (p0_valid)                                  grant0 = 1'b1;
    end
  end

  assign p0_ready   = grant0;
  assign p1_ready   = grant1;
  assign read_grant = (grant0 && !p0_we) || (grant1 && !p1_we);

  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = '0;
    mem_d    = '0;
    if (grant0) begin
      mem_cen  = 1'b0;
      mem_wen  = ~p0_we;
      mem_addr = p0_addr;
      mem_d    = p0_wdata;
    end else if (grant1) begin
      mem_cen  = 1'b0;
      mem_wen  = ~p1_we;
      mem_addr = p1_addr;
      mem_d    = p1_wdata;
    end
  end

  assign mem_oen = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rd_owner   <= '0;
    end else begin
      if (grant1 || !p1_valid)               starve_cnt <= '0;
      else if (grant0 && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
      rd_owner <= read_grant ? rd_owner_t'{valid: 1'b1, id: grant1} : '0;
    end
  end

  // Read data is returned only to the port that owns the access of the previous edge.
  assign p0_rvalid = rd_owner.valid && !rd_owner.id;
  assign p1_rvalid = rd_owner.valid &&  rd_owner.id;
  assign p0_rdata  = p0_rvalid ? mem_q : '0;
  assign p1_rdata  = p1_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM macro, vector table, directed corner sequences,
// and a randomized phase scored against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  logic              clk, rst_n;
  logic              p0_valid, p0_we, p1_valid, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr, mem_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_d, mem_q;
  logic              p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic              mem_cen, mem_wen, mem_oen;

  int n_pass  = 0;
  int n_total = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM macro: one-cycle read latency, writes land at the access edge.
  logic [DATA_W-1:0] ram [0:2047];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) ram[mem_addr] <= mem_d;
      else          mem_q <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [10:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [10:0] a1, input logic [31:0] d1);
    p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
  endtask

  // Apply new inputs in the low phase; outputs are then sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      drive(0, 0, '0, '0, 0, 0, '0, '0);
    end
  endtask

  typedef struct {
    logic v0; logic we0; logic [10:0] a0; logic [31:0] d0;
    logic v1; logic we1; logic [10:0] a1; logic [31:0] d1;
    logic r0; logic r1; logic cen; logic wen; logic [10:0] addr; logic [31:0] md;
    logic rv0; logic rv1;
  } vec_t;

  vec_t vecs [7];

  // Reference model state for the random phase
  logic [31:0] shadow [0:15];
  int          waited;
  logic        pend_rv0, pend_rv1;
  logic [31:0] pend_data;

  initial begin
    vecs[0] = '{0,0,11'h000,32'h0,     0,0,11'h000,32'h0,     0,0,1,1,11'h000,32'h0,     0,0};
    vecs[1] = '{1,0,11'h005,32'h1111,  0,0,11'h000,32'h0,     1,0,0,1,11'h005,32'h1111,  0,0};
    vecs[2] = '{0,0,11'h000,32'h0,     1,1,11'h040,32'h55AA,  0,1,0,0,11'h040,32'h55AA,  1,0};
    vecs[3] = '{1,0,11'h010,32'h3333,  1,0,11'h020,32'h4444,  1,0,0,1,11'h010,32'h3333,  0,0};
    vecs[4] = '{1,1,11'h011,32'h77,    0,0,11'h000,32'h0,     1,0,0,0,11'h011,32'h77,    1,0};
    vecs[5] = '{0,0,11'h000,32'h0,     1,0,11'h020,32'h5555,  0,1,0,1,11'h020,32'h5555,  0,0};
    vecs[6] = '{0,0,11'h000,32'h0,     0,0,11'h000,32'h0,     0,0,1,1,11'h000,32'h0,     0,1};

    ram[11'h005] = 32'h1234_5678;
    ram[11'h030] = 32'hA0A0_0030;
    ram[11'h031] = 32'hB1B1_0031;

    // ---- Reset with both ports requesting
    rst_n = 1'b0;
    drive(1, 0, 11'h001, 32'hFFFF_FFFF, 1, 0, 11'h002, 32'hEEEE_EEEE);
    next_cycle();
    #1;
    check("rst p0_ready", p0_ready, 0);
    check("rst p1_ready", p1_ready, 0);
    check("rst p0_rvalid", p0_rvalid, 0);
    check("rst p1_rvalid", p1_rvalid, 0);
    check("rst p0_rdata", p0_rdata, 0);
    check("rst p1_rdata", p1_rdata, 0);
    check("rst mem_cen", mem_cen, 1);
    check("rst mem_wen", mem_wen, 1);
    check("rst mem_oen", mem_oen, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_d", mem_d, 0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("release p0_ready", p0_ready, 1);
    check("release p1_ready", p1_ready, 0);
    check("release mem_addr", mem_addr, 11'h001);

    // ---- Vector table
    idle_cycles(2);
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("vec%0d p0_ready", i), p0_ready, vecs[i].r0);
      check($sformatf("vec%0d p1_ready", i), p1_ready, vecs[i].r1);
      check($sformatf("vec%0d mem_cen", i), mem_cen, vecs[i].cen);
      check($sformatf("vec%0d mem_wen", i), mem_wen, vecs[i].wen);
      check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("vec%0d mem_d", i), mem_d, vecs[i].md);
      check($sformatf("vec%0d p0_rvalid", i), p0_rvalid, vecs[i].rv0);
      check($sformatf("vec%0d p1_rvalid", i), p1_rvalid, vecs[i].rv1);
    end

    // ---- Single read of preloaded word 0x005
    idle_cycles(2);
    next_cycle();
    drive(1, 0, 11'h005, 32'h0, 0, 0, '0, '0);
    #1;
    check("single p0_ready", p0_ready, 1);
    next_cycle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #1;
    check("single p0_rvalid", p0_rvalid, 1);
    check("single p0_rdata", p0_rdata, 32'h1234_5678);
    check("single p1_rvalid", p1_rvalid, 0);

    // ---- Sustained contention: p0,p0,p0,p0,p1 repeating
    idle_cycles(2);
    for (int i = 0; i < 15; i++) begin
      logic exp1, prev1;
      next_cycle();
      drive(1, 0, 11'h030, '0, 1, 0, 11'h031, '0);
      #1;
      exp1  = (i % 5) == 4;
      prev1 = (i > 0) && ((i - 1) % 5) == 4;
      check($sformatf("cont%0d p1_ready", i), p1_ready, exp1);
      check($sformatf("cont%0d p0_ready", i), p0_ready, !exp1);
      check($sformatf("cont%0d p0_rvalid", i), p0_rvalid, i > 0 && !prev1);
      check($sformatf("cont%0d p1_rvalid", i), p1_rvalid, prev1);
      if (i > 0)
        check($sformatf("cont%0d rdata", i), prev1 ? p1_rdata : p0_rdata,
              prev1 ? 32'hB1B1_0031 : 32'hA0A0_0030);
    end

    // ---- Counter clear: 3 denials, p1 drops for a cycle, then 4 fresh denials before forcing
    idle_cycles(2);
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      drive(1, 0, 11'h030, '0, i != 3, 0, 11'h031, '0);
      #1;
      check($sformatf("clr%0d p1_ready", i), p1_ready, i == 8);
    end

    // ---- Write then read at 0x7FF
    idle_cycles(2);
    next_cycle();
    drive(0, 0, '0, '0, 1, 1, 11'h7FF, 32'hDEAD_BEEF);
    #1;
    check("raw write p1_ready", p1_ready, 1);
    check("raw write mem_wen", mem_wen, 0);
    next_cycle();
    drive(1, 0, 11'h7FF, '0, 0, 0, '0, '0);
    #1;
    check("raw read p0_ready", p0_ready, 1);
    check("raw read mem_wen", mem_wen, 1);
    next_cycle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #1;
    check("raw p0_rvalid", p0_rvalid, 1);
    check("raw p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    check("raw idle mem_wen", mem_wen, 1);

    // ---- Reset while a read is in flight
    idle_cycles(2);
    next_cycle();
    drive(1, 0, 11'h005, '0, 0, 0, '0, '0);
    #1;
    check("midrst p0_ready", p0_ready, 1);
    next_cycle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst during p0_rvalid", p0_rvalid, 0);
    check("midrst during p0_rdata", p0_rdata, 0);
    check("midrst during p1_rdata", p1_rdata, 0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("midrst after p0_rvalid", p0_rvalid, 0);
    check("midrst after p1_rvalid", p1_rvalid, 0);
    check("midrst after p0_rdata", p0_rdata, 0);
    check("midrst after p1_rdata", p1_rdata, 0);

    // ---- Randomized traffic against the reference model
    idle_cycles(2);
    for (int a = 0; a < 16; a++) begin
      shadow[a] = $urandom;
      ram[a]    = shadow[a];
    end
    waited   = 0;
    pend_rv0 = 1'b0;
    pend_rv1 = 1'b0;
    pend_data = '0;
    for (int c = 0; c < 400; c++) begin
      logic v0, v1, we0, we1, g0, g1;
      logic [10:0] a0, a1;
      logic [31:0] d0, d1;
      next_cycle();
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
      a0 = 11'($urandom_range(0, 15)); a1 = 11'($urandom_range(0, 15));
      d0 = $urandom; d1 = $urandom;
      drive(v0, we0, a0, d0, v1, we1, a1, d1);
      #1;
      // Port 1 wins when alone, or once it has been refused LIMIT times in a row.
      g1 = v1 && (!v0 || waited >= LIMIT);
      g0 = v0 && !g1;
      check($sformatf("rnd%0d p0_ready", c), p0_ready, g0);
      check($sformatf("rnd%0d p1_ready", c), p1_ready, g1);
      check($sformatf("rnd%0d p0_rvalid", c), p0_rvalid, pend_rv0);
      check($sformatf("rnd%0d p1_rvalid", c), p1_rvalid, pend_rv1);
      check($sformatf("rnd%0d p0_rdata", c), p0_rdata, pend_rv0 ? pend_data : 32'h0);
      check($sformatf("rnd%0d p1_rdata", c), p1_rdata, pend_rv1 ? pend_data : 32'h0);
      waited   = (v1 && !g1) ? waited + 1 : 0;
      pend_rv0 = g0 && !we0;
      pend_rv1 = g1 && !we1;
      pend_data = '0;
      if (g0) begin
        if (we0) shadow[a0[3:0]] = d0;
        else     pend_data = shadow[a0[3:0]];
      end else if (g1) begin
        if (we1) shadow[a1[3:0]] = d1;
        else     pend_data = shadow[a1[3:0]];
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
